// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Saturates to all nines and flags overflow when the input exceeds the digit range.
module bin_to_bcd #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t          state_q;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   scr_q, scr_d, adj;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, ovfo_q;
    logic [BW-1:0]   bcd_q;
    logic            last;

    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        scr_d = {adj[BW-2:0], bin_q[WIDTH-1]};
        // A bit leaving the top nibble means the value no longer fits
        ovf_d = ovf_q | adj[BW-1];
        bin_d = bin_q << 1;
        last  = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovfo_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        scr_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bin_q <= bin_d;
                    scr_q <= scr_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        bcd_q   <= ovf_d ? {DIGITS{4'h9}} : scr_d;
                        ovfo_q  <= ovf_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovfo_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd: 14-bit/4-digit and 7-bit/2-digit instances.
module tb_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [13:0] bin = '0;
    logic [6:0]  bin2 = '0;
    logic        busy, done, ovf;
    logic        busy2, done2, ovf2;
    logic [15:0] bcd;
    logic [7:0]  bcd2;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    bin_to_bcd #(.WIDTH(14), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(ovf)
    );

    bin_to_bcd #(.WIDTH(7), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
    );

    function automatic logic [15:0] ref4(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] ref2(input int v);
        if (v > 99) return 8'h99;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int f(input int i);
        return (i * 397 + 11) % 16384;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic conv(input int v);
        int lat;
        int bsy;
        @(negedge clk);
        start = 1'b1;
        bin   = 14'(v);
        @(negedge clk);
        start = 1'b0;
        bin   = ~bin;
        lat   = 0;
        bsy   = 0;
        while (!done && lat < 64) begin
            if (busy) bsy++;
            start = (lat == 5);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk($sformatf("latency(%0d)", v), lat, 14);
        chk($sformatf("busy_cycles(%0d)", v), bsy, 14);
        chk($sformatf("busy_at_done(%0d)", v), busy, 0);
        chk($sformatf("bcd(%0d)", v), bcd, ref4(v));
        chk($sformatf("ovf(%0d)", v), ovf, v > 9999);
    endtask

    task automatic conv2(input int v);
        int lat;
        @(negedge clk);
        start2 = 1'b1;
        bin2   = 7'(v);
        @(negedge clk);
        start2 = 1'b0;
        lat    = 0;
        while (!done2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("lat2(%0d)", v), lat, 7);
        chk($sformatf("bcd2(%0d)", v), bcd2, ref2(v));
        chk($sformatf("ovf2(%0d)", v), ovf2, v > 99);
    endtask

    initial begin
        int hits;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;

        conv(0);
        conv(1234);
        conv(9999);
        conv(7);
        conv(10000);
        conv(16383);
        conv(42);

        // start held high with bin changing every cycle
        for (int i = 0; i < 48; i++) begin
            if (i > 0) begin
                chk($sformatf("stream_done[%0d]", i), done, (i % 15) == 0);
                chk($sformatf("stream_excl[%0d]", i), busy & done, 0);
                if (i % 15 == 0) begin
                    chk($sformatf("stream_bcd[%0d]", i), bcd, ref4(f(i - 15)));
                    chk($sformatf("stream_ovf[%0d]", i), ovf, f(i - 15) > 9999);
                end
            end
            start = (i < 40);
            bin   = 14'(f(i));
            @(negedge clk);
        end
        start = 1'b0;

        conv(1234);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_bcd", bcd, 16'h1234);
        chk("hold_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_bcd", bcd, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ovf", ovf, 0);
        @(negedge clk);
        rst  = 1'b0;
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) hits++;
        end
        chk("abort_no_done", hits, 0);
        conv(5678);

        for (int v = 0; v <= 9999; v += 101) conv(v);

        conv2(0);
        conv2(99);
        conv2(100);
        conv2(127);
        repeat (20) conv2(int'($urandom_range(0, 127)));

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
